// File: rtl/acia_bus_sequencer.sv
// Autonomous 6850-style bus master: programs the ACIA control register once, then polls
// status and moves bytes between the ACIA and one RX sink / two round-robin TX requesters.
module acia_bus_sequencer #(
  parameter logic [7:0]  CTRL_INIT = 8'h15,
  parameter int unsigned POLL_GAP  = 4
) (
  input  logic       i_clk,
  input  logic       i_rst,
  output logic       o_acia_e,
  output logic       o_acia_rs,
  output logic       o_acia_rw_n,
  output logic [7:0] o_acia_dout,
  output logic       o_acia_doe,
  input  logic [7:0] i_acia_din,
  input  logic       i_tx0_valid,
  input  logic [7:0] i_tx0_data,
  output logic       o_tx0_ready,
  input  logic       i_tx1_valid,
  input  logic [7:0] i_tx1_data,
  output logic       o_tx1_ready,
  output logic       o_rx_valid,
  output logic [7:0] o_rx_data,
  input  logic       i_rx_ready,
  output logic       o_busy_init
);

  typedef enum logic [2:0] {StInit, StGap, StPoll, StDecide, StRd, StWr} state_e;
  typedef enum logic [1:0] {PhIdle, PhSetup, PhStrobe, PhHold} phase_e;

  localparam int unsigned GW = (POLL_GAP > 2) ? $clog2(POLL_GAP) : 1;
  localparam logic [GW-1:0] GapLast = GW'(POLL_GAP - 1);
  // With no idle gap, a finished bus cycle goes straight into the next status poll.
  localparam state_e AfterState = (POLL_GAP == 0) ? StPoll : StGap;
  localparam phase_e AfterPhase = (POLL_GAP == 0) ? PhSetup : PhIdle;

  state_e      r_state, w_state_d;
  phase_e      r_phase, w_phase_d;
  logic [GW-1:0] r_gap, w_gap_d;
  logic [1:0]  r_status;
  logic        r_grant;
  logic        r_last;
  logic [7:0]  r_dout;
  logic        r_rx_valid;
  logic [7:0]  r_rx_data;
  logic        r_busy;

  logic w_grant;
  logic w_strobe;
  logic w_active;
  logic w_write;

  assign w_grant  = (i_tx0_valid && i_tx1_valid) ? ~r_last : i_tx1_valid;
  assign w_strobe = (r_phase == PhStrobe);
  assign w_active = (r_phase != PhIdle);
  assign w_write  = (r_state == StInit) || (r_state == StWr);

  always_comb begin
    w_state_d = r_state;
    w_phase_d = r_phase;
    w_gap_d   = r_gap;
    unique case (r_state)
      StInit, StPoll, StRd, StWr: begin
        unique case (r_phase)
          PhIdle:   w_phase_d = PhSetup;
          PhSetup:  w_phase_d = PhStrobe;
          PhStrobe: w_phase_d = PhHold;
          PhHold: begin
            if (r_state == StPoll) begin
              w_state_d = StDecide;
              w_phase_d = PhIdle;
            end else begin
              w_state_d = AfterState;
              w_phase_d = AfterPhase;
              w_gap_d   = '0;
            end
          end
        endcase
      end
      StGap: begin
        if (r_gap == GapLast) begin
          w_state_d = StPoll;
          w_phase_d = PhSetup;
        end else begin
          w_gap_d = r_gap + 1'b1;
        end
      end
      StDecide: begin
        // RX first: a full holding register leaves the byte waiting inside the ACIA.
        if (r_status[0] && !r_rx_valid) begin
          w_state_d = StRd;
          w_phase_d = PhSetup;
        end else if (r_status[1] && (i_tx0_valid || i_tx1_valid)) begin
          w_state_d = StWr;
          w_phase_d = PhSetup;
        end else begin
          w_state_d = AfterState;
          w_phase_d = AfterPhase;
          w_gap_d   = '0;
        end
      end
      default: begin
        w_state_d = StInit;
        w_phase_d = PhIdle;
      end
    endcase
  end

  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) begin
      r_state    <= StInit;
      r_phase    <= PhIdle;
      r_gap      <= '0;
      r_status   <= '0;
      r_grant    <= 1'b0;
      r_last     <= 1'b1;
      r_dout     <= '0;
      r_rx_valid <= 1'b0;
      r_rx_data  <= '0;
      r_busy     <= 1'b1;
    end else begin
      r_state <= w_state_d;
      r_phase <= w_phase_d;
      r_gap   <= w_gap_d;
      if (r_state == StInit && r_phase == PhIdle) begin
        r_dout <= CTRL_INIT;
      end
      // Grant and byte are frozen here so a late VALID drop cannot change the transfer.
      if (r_state == StDecide && w_state_d == StWr) begin
        r_grant <= w_grant;
        r_dout  <= w_grant ? i_tx1_data : i_tx0_data;
      end
      if (w_strobe && r_state == StPoll) begin
        r_status <= i_acia_din[1:0];
      end
      if (w_strobe && r_state == StWr) begin
        r_last <= r_grant;
      end
      if (r_state == StInit && r_phase == PhHold) begin
        r_busy <= 1'b0;
      end
      if (w_strobe && r_state == StRd) begin
        r_rx_valid <= 1'b1;
        r_rx_data  <= i_acia_din;
      end else if (r_rx_valid && i_rx_ready) begin
        r_rx_valid <= 1'b0;
      end
    end
  end

  assign o_acia_e    = w_strobe;
  assign o_acia_rs   = w_active && ((r_state == StRd) || (r_state == StWr));
  assign o_acia_rw_n = ~(w_active && w_write);
  assign o_acia_doe  = w_active && w_write;
  assign o_acia_dout = r_dout;
  assign o_tx0_ready = w_strobe && (r_state == StWr) && ~r_grant;
  assign o_tx1_ready = w_strobe && (r_state == StWr) && r_grant;
  assign o_rx_valid  = r_rx_valid;
  assign o_rx_data   = r_rx_data;
  assign o_busy_init = r_busy;

endmodule

// File: tb/tb_acia_bus_sequencer.sv
// Directed bench for acia_bus_sequencer with a small behavioural ACIA (status/data regs,
// RX byte queue, TDRE busy timer) attached to its bus.
module tb_acia_bus_sequencer;

  localparam int TX_TIME = 20;

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic       acia_e, acia_rs, acia_rw_n, acia_doe;
  logic [7:0] acia_dout, acia_din;
  logic       tx0_valid = 1'b0, tx1_valid = 1'b0;
  logic [7:0] tx0_data = 8'h00, tx1_data = 8'h00;
  logic       tx0_ready, tx1_ready;
  logic       rx_valid;
  logic [7:0] rx_data;
  logic       rx_ready = 1'b0;
  logic       busy_init;

  always #5 clk = ~clk;

  acia_bus_sequencer #(.CTRL_INIT(8'h15), .POLL_GAP(4)) dut (
    .i_clk(clk), .i_rst(rst),
    .o_acia_e(acia_e), .o_acia_rs(acia_rs), .o_acia_rw_n(acia_rw_n),
    .o_acia_dout(acia_dout), .o_acia_doe(acia_doe), .i_acia_din(acia_din),
    .i_tx0_valid(tx0_valid), .i_tx0_data(tx0_data), .o_tx0_ready(tx0_ready),
    .i_tx1_valid(tx1_valid), .i_tx1_data(tx1_data), .o_tx1_ready(tx1_ready),
    .o_rx_valid(rx_valid), .o_rx_data(rx_data), .i_rx_ready(rx_ready),
    .o_busy_init(busy_init)
  );

  // Behavioural ACIA
  logic [7:0] rx_byte = 8'h00;
  logic       rdrf = 1'b0, tdre = 1'b1, blk = 1'b0;
  int         tx_cnt = 0;
  logic [7:0] rx_q[$];
  logic [7:0] txlog[$];
  logic [7:0] ctrllog[$];
  int         rdylog[$];
  int         nrd = 0, elong = 0, both_err = 0;
  logic       prev_e = 1'b0, cap_e = 1'b0, cap_rs = 1'b0, cap_rw = 1'b1;

  assign acia_din = acia_rs ? rx_byte : {6'b0, tdre & ~blk, rdrf & ~blk};

  always @(negedge clk) begin
    cap_e  = acia_e;
    cap_rs = acia_rs;
    cap_rw = acia_rw_n;
    if (acia_e && !acia_rw_n) begin
      if (acia_rs) txlog.push_back(acia_dout);
      else ctrllog.push_back(acia_dout);
    end
    if (acia_e && acia_rs && acia_rw_n) nrd++;
    if (tx0_ready && tx1_ready) both_err++;
    if (tx0_ready) rdylog.push_back(0);
    if (tx1_ready) rdylog.push_back(1);
    if (acia_e && prev_e) elong++;
    prev_e = acia_e;
  end

  always @(posedge clk) begin
    if (cap_e && cap_rs && cap_rw) rdrf <= 1'b0;
    else if (!rdrf && rx_q.size() != 0) begin
      rx_byte <= rx_q.pop_front();
      rdrf    <= 1'b1;
    end
    if (cap_e && cap_rs && !cap_rw) begin
      tdre   <= 1'b0;
      tx_cnt <= TX_TIME;
    end else if (tx_cnt > 1) tx_cnt <= tx_cnt - 1;
    else if (tx_cnt == 1) begin
      tx_cnt <= 0;
      tdre   <= 1'b1;
    end
  end

  int n_pass = 0, n_fail = 0, n_checks = 0;
  int tmo, base_w, base_r, base_c;
  logic idle_e;
  logic [7:0] exp_tx[4] = '{8'hA1, 8'hB2, 8'hA1, 8'hB2};
  int exp_src[4] = '{0, 1, 0, 1};

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    assert (obs === exp) n_pass++;
    else begin
      n_fail++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  initial begin
    repeat (3) @(posedge clk);
    #1;
    chk("rst_e", acia_e, 0);
    chk("rst_rw_n", acia_rw_n, 1);
    chk("rst_doe", acia_doe, 0);
    chk("rst_dout", acia_dout, 0);
    chk("rst_busy", busy_init, 1);
    chk("rst_rx_valid", rx_valid, 0);
    chk("rst_rx_data", rx_data, 0);
    chk("rst_ready", {tx1_ready, tx0_ready}, 0);

    // Init control write
    @(negedge clk);
    rst = 1'b0;
    #1;
    chk("init_pre_doe", acia_doe, 0);
    tick();
    chk("init_setup_rw_n", acia_rw_n, 0);
    chk("init_setup_doe", acia_doe, 1);
    chk("init_setup_rs", acia_rs, 0);
    chk("init_setup_dout", acia_dout, 8'h15);
    chk("init_setup_e", acia_e, 0);
    tick();
    chk("init_strobe_e", acia_e, 1);
    tick();
    chk("init_hold_e", acia_e, 0);
    chk("init_hold_doe", acia_doe, 1);
    chk("init_hold_busy", busy_init, 1);
    tick();
    chk("init_done_busy", busy_init, 0);
    chk("init_done_doe", acia_doe, 0);
    idle_e = acia_e;
    for (int i = 0; i < 4; i++) begin
      tick();
      idle_e = idle_e | acia_e;
    end
    chk("gap_idle_e", idle_e, 0);
    tick();
    chk("poll_strobe_e", acia_e, 1);
    chk("poll_rs", acia_rs, 0);
    chk("poll_rw_n", acia_rw_n, 1);
    chk("ctrl_count", ctrllog.size(), 1);
    chk("ctrl_byte", ctrllog[0], 8'h15);

    // Single RX byte
    rx_q.push_back(8'h5A);
    tmo = 1;
    for (int i = 0; i < 200; i++) begin
      tick();
      if (rx_valid) begin tmo = 0; break; end
    end
    chk("rx1_timeout", tmo, 0);
    chk("rx1_data", rx_data, 8'h5A);
    chk("rx1_reads", nrd, 1);
    repeat (20) tick();
    chk("rx1_rdrf_clear", rdrf, 0);
    chk("rx1_no_reread", nrd, 1);
    rx_ready = 1'b1;
    tick();
    chk("rx1_drained", rx_valid, 0);
    rx_ready = 1'b0;

    // RX back-pressure
    rx_q.push_back(8'h11);
    rx_q.push_back(8'h22);
    tmo = 1;
    for (int i = 0; i < 200; i++) begin
      tick();
      if (rx_valid) begin tmo = 0; break; end
    end
    chk("bp_timeout1", tmo, 0);
    chk("bp_data1", rx_data, 8'h11);
    repeat (80) tick();
    chk("bp_reads_held", nrd, 2);
    chk("bp_valid_held", rx_valid, 1);
    chk("bp_data_held", rx_data, 8'h11);
    chk("bp_acia_waiting", rdrf, 1);
    rx_ready = 1'b1;
    tick();
    chk("bp_cleared", rx_valid, 0);
    rx_ready = 1'b0;
    tmo = 1;
    for (int i = 0; i < 200; i++) begin
      tick();
      if (rx_valid) begin tmo = 0; break; end
    end
    chk("bp_timeout2", tmo, 0);
    chk("bp_data2", rx_data, 8'h22);
    chk("bp_reads_after", nrd, 3);
    rx_ready = 1'b1;
    tick();
    rx_ready = 1'b0;

    // Round-robin TX
    base_w = txlog.size();
    base_r = rdylog.size();
    tx0_data = 8'hA1; tx0_valid = 1'b1;
    tx1_data = 8'hB2; tx1_valid = 1'b1;
    tmo = 1;
    for (int i = 0; i < 1000; i++) begin
      tick();
      if (txlog.size() >= base_w + 4) begin tmo = 0; break; end
    end
    tx0_valid = 1'b0;
    tx1_valid = 1'b0;
    chk("rr_timeout", tmo, 0);
    for (int i = 0; i < 4; i++) begin
      chk($sformatf("rr_byte%0d", i), txlog[base_w+i], exp_tx[i]);
      chk($sformatf("rr_src%0d", i), rdylog[base_r+i], exp_src[i]);
    end
    repeat (5) tick();
    chk("rr_ready_count", rdylog.size() - base_r, 4);

    // RX beats TX when both flags appear together
    blk = 1'b1;
    rx_q.push_back(8'h77);
    tx0_data = 8'hC3; tx0_valid = 1'b1;
    base_w = txlog.size();
    base_r = rdylog.size();
    repeat (40) tick();
    blk = 1'b0;
    tmo = 1;
    for (int i = 0; i < 200; i++) begin
      tick();
      if (rx_valid) begin tmo = 0; break; end
    end
    chk("prio_rx_timeout", tmo, 0);
    chk("prio_rx_data", rx_data, 8'h77);
    chk("prio_no_write_yet", txlog.size(), base_w);
    chk("prio_no_ready_yet", rdylog.size(), base_r);
    tmo = 1;
    for (int i = 0; i < 300; i++) begin
      tick();
      if (txlog.size() > base_w) begin tmo = 0; break; end
    end
    chk("prio_tx_timeout", tmo, 0);
    chk("prio_tx_byte", txlog[base_w], 8'hC3);
    chk("prio_tx_src", rdylog[base_r], 0);
    tx0_valid = 1'b0;
    rx_ready = 1'b1;
    tick();
    rx_ready = 1'b0;

    // Reset during a WR strobe
    base_c = ctrllog.size();
    tx0_data = 8'hA1; tx0_valid = 1'b1;
    tx1_data = 8'hB2; tx1_valid = 1'b1;
    tmo = 1;
    for (int i = 0; i < 300; i++) begin
      tick();
      if (acia_e && !acia_rw_n && acia_rs) begin tmo = 0; break; end
    end
    chk("abort_timeout", tmo, 0);
    chk("abort_grant_tx1", tx1_ready, 1);
    chk("abort_grant_tx0", tx0_ready, 0);
    rst = 1'b1;
    #1;
    chk("abort_e", acia_e, 0);
    chk("abort_doe", acia_doe, 0);
    chk("abort_rw_n", acia_rw_n, 1);
    chk("abort_ready", {tx1_ready, tx0_ready}, 0);
    chk("abort_busy", busy_init, 1);
    repeat (2) tick();
    base_w = txlog.size();
    base_r = rdylog.size();
    rst = 1'b0;
    tmo = 1;
    for (int i = 0; i < 300; i++) begin
      tick();
      if (txlog.size() > base_w) begin tmo = 0; break; end
    end
    tx0_valid = 1'b0;
    tx1_valid = 1'b0;
    chk("reinit_timeout", tmo, 0);
    chk("reinit_ctrl", ctrllog.size(), base_c + 1);
    chk("reinit_tx_byte", txlog[base_w], 8'hA1);
    chk("reinit_tx_src", rdylog[base_r], 0);

    repeat (10) tick();
    chk("e_single_cycle", elong, 0);
    chk("ready_exclusive", both_err, 0);

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
